// File: rtl/random_led_array_controller.sv
// Random target LED picker with difficulty-dependent colouring and a
// continuously refreshed WS2811 frame serializer (LED 0 first, MSB first).
module random_led_array_controller #(
    parameter int N_LEDS       = 16,
    parameter int POS_W        = $clog2(N_LEDS),
    parameter int T0H          = 25,
    parameter int T1H          = 60,
    parameter int TBIT         = 125,
    parameter int RESET_CYCLES = 2500,
    parameter int FADE_STEP    = 50000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             gerar_jogada,
    input  logic             trigger,
    input  logic [9:0]       contador_jogo,
    input  logic [9:0]       mid_idx,
    input  logic [9:0]       max_idx,
    input  logic [1:0]       nivel_dificuldade,
    output logic [POS_W-1:0] position_led,
    output logic             frame_done,
    output logic             serial,
    output logic             db_serial
);
    localparam int TK_W = $clog2(TBIT + 1);
    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam int FS_W = $clog2(FADE_STEP + 1);
    localparam int BL_W = $clog2(BLINK_CYCLES + 1);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [15:0]      lfsr_q, lfsr_d;
    logic [POS_W-1:0] pos_q, pos_d, cand;
    logic [16:0]      prod;
    logic [7:0]       bright_q, bright_d;
    logic [FS_W-1:0]  fstep_q, fstep_d;
    logic [BL_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic             blink_tog_q, blink_tog_d;
    logic [23:0]      base_col, fade_col, out_col;
    logic [1:0]       state_q, state_d;
    logic [TK_W-1:0]  tick_q, tick_d, hi_len;
    logic [4:0]       bitn_q, bitn_d;
    logic [POS_W-1:0] led_q, led_d, snap_pos_q, snap_pos_d;
    logic [RC_W-1:0]  lat_q, lat_d;
    logic [23:0]      snap_col_q, snap_col_d, sr_q, sr_d;
    logic             serial_q, serial_d, frame_done_q, frame_done_d;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = 17'(c) * (17'(b) + 17'd1);
        return 8'(p >> 8);
    endfunction

    // Galois LFSR and collision-free position draw
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        prod   = 17'(lfsr_q[7:0]) * 17'(N_LEDS);
        cand   = POS_W'(prod >> 8);
        pos_d  = pos_q;
        if (gerar_jogada) begin
            if (cand != pos_q)                    pos_d = cand;
            else if (cand == POS_W'(N_LEDS - 1))  pos_d = '0;
            else                                  pos_d = cand + POS_W'(1);
        end
    end

    always_comb begin
        bright_d = bright_q;
        fstep_d  = fstep_q;
        if (trigger || gerar_jogada) begin
            bright_d = 8'hFF;
            fstep_d  = '0;
        end else if (fstep_q == FS_W'(FADE_STEP - 1)) begin
            fstep_d = '0;
            if (bright_q != 8'd0) bright_d = bright_q - 8'd1;
        end else begin
            fstep_d = fstep_q + FS_W'(1);
        end

        blink_cnt_d = blink_cnt_q + BL_W'(1);
        blink_tog_d = blink_tog_q;
        if (blink_cnt_q == BL_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            blink_tog_d = ~blink_tog_q;
        end
    end

    always_comb begin
        if (contador_jogo < mid_idx)      base_col = 24'h00FF00;
        else if (contador_jogo < max_idx) base_col = 24'hFFFF00;
        else                              base_col = 24'hFF0000;
        fade_col = {scale(base_col[23:16], bright_q), scale(base_col[15:8], bright_q),
                    scale(base_col[7:0], bright_q)};
        case (nivel_dificuldade)
            2'b10:   out_col = blink_tog_q ? base_col : 24'h0;
            2'b11:   out_col = fade_col;
            default: out_col = base_col;
        endcase
    end

    // Frame sequencer; serial is registered from next-state values so it
    // lines up with the state it belongs to without a combinational output.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bitn_d     = bitn_q;
        led_d      = led_q;
        lat_d      = lat_q;
        snap_pos_d = snap_pos_q;
        snap_col_d = snap_col_q;
        sr_d       = sr_q;
        case (state_q)
            S_LOAD: begin
                state_d    = S_SEND;
                tick_d     = '0;
                bitn_d     = '0;
                led_d      = '0;
                snap_pos_d = pos_q;
                snap_col_d = out_col;
                sr_d       = (pos_q == '0) ? out_col : 24'h0;
            end
            S_SEND: begin
                if (tick_q == TK_W'(TBIT - 1)) begin
                    tick_d = '0;
                    if (bitn_q == 5'd23) begin
                        bitn_d = '0;
                        if (led_q == POS_W'(N_LEDS - 1)) begin
                            state_d = S_LATCH;
                            lat_d   = '0;
                        end else begin
                            led_d = led_q + POS_W'(1);
                            sr_d  = (led_q + POS_W'(1) == snap_pos_q) ? snap_col_q : 24'h0;
                        end
                    end else begin
                        bitn_d = bitn_q + 5'd1;
                        sr_d   = {sr_q[22:0], 1'b0};
                    end
                end else begin
                    tick_d = tick_q + TK_W'(1);
                end
            end
            default: begin
                if (lat_q == RC_W'(RESET_CYCLES - 1)) state_d = S_LOAD;
                else                                  lat_d   = lat_q + RC_W'(1);
            end
        endcase
        hi_len       = sr_d[23] ? TK_W'(T1H) : TK_W'(T0H);
        serial_d     = (state_d == S_SEND) && (tick_d < hi_len);
        frame_done_d = (state_d == S_LATCH) && (lat_d == RC_W'(RESET_CYCLES - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q       <= 16'hACE1;
            pos_q        <= '0;
            bright_q     <= 8'hFF;
            fstep_q      <= '0;
            blink_cnt_q  <= '0;
            blink_tog_q  <= 1'b1;
            state_q      <= S_LOAD;
            tick_q       <= '0;
            bitn_q       <= '0;
            led_q        <= '0;
            lat_q        <= '0;
            snap_pos_q   <= '0;
            snap_col_q   <= '0;
            sr_q         <= '0;
            serial_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            pos_q        <= pos_d;
            bright_q     <= bright_d;
            fstep_q      <= fstep_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_tog_q  <= blink_tog_d;
            state_q      <= state_d;
            tick_q       <= tick_d;
            bitn_q       <= bitn_d;
            led_q        <= led_d;
            lat_q        <= lat_d;
            snap_pos_q   <= snap_pos_d;
            snap_col_q   <= snap_col_d;
            sr_q         <= sr_d;
            serial_q     <= serial_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign position_led = pos_q;
    assign frame_done   = frame_done_q;
    assign serial       = serial_q;
    assign db_serial    = serial_q;
endmodule

// File: tb/tb_random_led_array_controller.sv
// Directed bench: decodes whole WS2811 frames from the serial pin and checks
// colours, positions, fade/blink behaviour and mid-frame reset.
module tb_random_led_array_controller;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       gerar_jogada = 1'b0;
    logic       trigger = 1'b0;
    logic [9:0] contador_jogo = 10'd0;
    logic [9:0] mid_idx = 10'd5;
    logic [9:0] max_idx = 10'd9;
    logic [1:0] nivel_dificuldade = 2'b00;
    logic [1:0] position_led;
    logic       frame_done, serial, db_serial;

    random_led_array_controller #(
        .N_LEDS(4), .T0H(3), .T1H(7), .TBIT(10), .RESET_CYCLES(20),
        .FADE_STEP(4), .BLINK_CYCLES(1500)
    ) dut (
        .clock(clock), .reset(reset), .gerar_jogada(gerar_jogada), .trigger(trigger),
        .contador_jogo(contador_jogo), .mid_idx(mid_idx), .max_idx(max_idx),
        .nivel_dificuldade(nivel_dificuldade), .position_led(position_led),
        .frame_done(frame_done), .serial(serial), .db_serial(db_serial)
    );

    always #5 clock = ~clock;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          load_cyc;
    logic [15:0] m_lfsr  = 16'hACE1;
    logic [1:0]  exp_pos = 2'd0;
    logic [23:0] cap [4];
    logic [9:0]  nxt_cj = 10'd0;
    logic [1:0]  nxt_mode = 2'b00;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting Galois form.
    always @(posedge clock) begin
        cyc    <= reset ? 0 : cyc + 1;
        m_lfsr <= reset ? 16'hACE1 : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0));
    end

    function automatic logic [1:0] cand_of(input logic [15:0] l);
        logic [16:0] p;
        p = 17'(l[7:0]) * 17'd4;
        return p[9:8];
    endfunction

    function automatic logic [1:0] draw_model(input logic [1:0] c, input logic [1:0] p);
        if (c != p) return c;
        return (c == 2'd3) ? 2'd0 : c + 2'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step_inputs(input int off, input int trig_at, input int act_at);
        trigger = (off == trig_at);
        if (off == act_at) begin
            contador_jogo     = nxt_cj;
            nivel_dificuldade = nxt_mode;
        end
    endtask

    // Entered at the negedge of a LOAD cycle; leaves at the next LOAD negedge.
    task automatic capture(input int trig_at, input int act_at);
        int off, highs;
        bit seen_low, shape_bad, fd_bad, lat_bad;
        logic [23:0] word;
        shape_bad = 0; fd_bad = 0; lat_bad = 0; off = 0;
        load_cyc = cyc + 1;
        chk("load_low", serial, 0);
        for (int l = 0; l < 4; l++) begin
            word = '0;
            for (int b = 0; b < 24; b++) begin
                highs = 0; seen_low = 0;
                for (int t = 0; t < 10; t++) begin
                    @(negedge clock); off++; step_inputs(off, trig_at, act_at);
                    if (serial === 1'b1) begin
                        highs++;
                        if (seen_low) shape_bad = 1;
                    end else seen_low = 1;
                    if (db_serial !== serial) shape_bad = 1;
                    if (frame_done !== 1'b0) fd_bad = 1;
                end
                if (highs != 3 && highs != 7) shape_bad = 1;
                word = {word[22:0], highs == 7};
            end
            cap[l] = word;
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clock); off++; step_inputs(off, trig_at, act_at);
            if (serial !== 1'b0) lat_bad = 1;
            if (frame_done !== (t == 19)) fd_bad = 1;
        end
        @(negedge clock); off++; step_inputs(off, trig_at, act_at);
        chk("bit_shape", shape_bad, 0);
        chk("latch_low", lat_bad, 0);
        chk("frame_done_timing", fd_bad, 0);
    endtask

    task automatic check_frame(input string tag, input int pos, input logic [23:0] col);
        for (int l = 0; l < 4; l++)
            chk($sformatf("%s_led%0d", tag, l), cap[l], (l == pos) ? col : 24'h0);
    endtask

    task automatic wait_load();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 3000) begin
            @(negedge clock); n++;
        end
        chk("wait_frame_done", n < 3000, 1);
        @(negedge clock);
    endtask

    task automatic draw_when(input logic [1:0] want, input bit need_diff,
                             input logic [1:0] exp_after, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clock);
            if (cand_of(m_lfsr) == want && (!need_diff || exp_pos != want)) begin
                found = 1;
                gerar_jogada = 1'b1;
                @(negedge clock);
                gerar_jogada = 1'b0;
                chk(tag, position_led, exp_after);
                exp_pos = exp_after;
            end
        end
        chk({tag, "_found"}, found, 1);
    endtask

    initial begin
        logic [1:0] nxt, prev;
        bit found, tog;

        repeat (3) @(negedge clock);
        chk("rst_pos", position_led, 0);
        chk("rst_serial", serial, 0);
        chk("rst_db_serial", db_serial, 0);
        chk("rst_frame_done", frame_done, 0);
        reset = 1'b0;

        // Colour thresholds; changes land mid-frame and show one frame later
        nxt_cj = 10'd6;
        capture(-1, 500);  check_frame("green", 0, 24'h00FF00);
        nxt_cj = 10'd9;
        capture(-1, 500);  check_frame("yellow", 0, 24'hFFFF00);
        capture(-1, -1);   check_frame("red", 0, 24'hFF0000);

        // Position draws: collision bump, wrap at N_LEDS-1, long held pulse
        contador_jogo = 10'd0;
        draw_when(2'd0, 1'b0, 2'd1, "collide_bump");
        draw_when(2'd3, 1'b1, 2'd3, "draw_to_3");
        draw_when(2'd3, 1'b0, 2'd0, "collide_wrap");
        @(negedge clock);
        gerar_jogada = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            prev = exp_pos;
            nxt  = draw_model(cand_of(m_lfsr), exp_pos);
            @(negedge clock);
            chk("held_draw", position_led, nxt);
            chk("no_repeat", position_led != prev, 1);
            exp_pos = nxt;
        end
        gerar_jogada = 1'b0;

        // Fade mode: trigger 42 cycles before LOAD gives b=245
        wait_load();
        nxt_cj = 10'd0; nxt_mode = 2'b11;
        capture(-1, 500);  check_frame("pos_on_strip", exp_pos, 24'h00FF00);
        capture(939, -1);
        capture(-1, -1);   check_frame("fade_245", exp_pos, 24'h00F500);
        capture(980, -1);  check_frame("fade_zero", exp_pos, 24'h000000);
        nxt_cj = 10'd6; nxt_mode = 2'b10;
        capture(-1, 500);  check_frame("fade_retrig", exp_pos, 24'h00FF00);

        // Blink mode: toggle starts at 1 after reset, flips every 1500 cycles
        nxt_cj = 10'd9; nxt_mode = 2'b00;
        for (int f = 0; f < 4; f++) begin
            capture(-1, (f == 3) ? 500 : -1);
            tog = (((load_cyc - 1) / 1500) % 2) == 0;
            check_frame($sformatf("blink%0d", f), exp_pos, tog ? 24'hFFFF00 : 24'h000000);
        end

        // Reset while a bit is high: line drops next edge, fresh frame follows
        repeat (100) @(negedge clock);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (serial === 1'b1) found = 1;
            else @(negedge clock);
        end
        chk("found_high_bit", found, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_serial", serial, 0);
        chk("midrst_db_serial", db_serial, 0);
        chk("midrst_pos", position_led, 0);
        chk("midrst_frame_done", frame_done, 0);
        reset = 1'b0;
        exp_pos = 2'd0;
        capture(-1, -1);   check_frame("after_rst", 0, 24'hFF0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
